// File: rtl/NetworkPkg.sv
// Shared network types: the packet carried through the crossbar and
// the round-robin pointer type used by per-destination arbiters.
package NetworkPkg;

  localparam int NUM_PROC   = 4;
  localparam int ID_SIZE    = $clog2(NUM_PROC);
  localparam int DATA_WIDTH = 16;

  typedef logic [$clog2(NUM_PROC)-1:0] rr_ptr_t;

  typedef struct packed {
    logic [ID_SIZE-1:0]    src;
    logic [ID_SIZE-1:0]    dest;
    logic [DATA_WIDTH-1:0] memoryAddress;
  } pkt_t;

endpackage

// File: rtl/pkt_fifo.sv
// Per-source packet queue: power-of-two circular buffer with a registered
// entry count; the head entry is presented combinationally.
module pkt_fifo
  import NetworkPkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   push,
  input  logic                   pop,
  input  pkt_t                   din,
  output pkt_t                   head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  pkt_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop
  // never opens room for a push into a full queue.
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/buffered_crossbar.sv
// Input-queued crossbar: one FIFO per source, one round-robin arbiter and
// one output holding register per destination.
module buffered_crossbar
  import NetworkPkg::*;
#(
  parameter int NUM_PROC = 4,
  parameter int DEPTH    = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  pkt_t [NUM_PROC-1:0]                   packetSendIn,
  input  logic [NUM_PROC-1:0]                   packetCoreIn,
  output logic [NUM_PROC-1:0]                   acceptedOut,
  output logic [NUM_PROC-1:0]                   full,
  output logic [NUM_PROC-1:0][$clog2(DEPTH):0]  occupancy,
  output pkt_t [NUM_PROC-1:0]                   packetReceived,
  output logic [NUM_PROC-1:0]                   received,
  input  logic [NUM_PROC-1:0]                   outReady
);

  localparam int PW = $clog2(NUM_PROC);

  pkt_t [NUM_PROC-1:0]                 head;
  logic [NUM_PROC-1:0]                 empty;
  logic [NUM_PROC-1:0]                 pop;
  logic [NUM_PROC-1:0]                 ofree;
  logic [NUM_PROC-1:0]                 gnt_vld;
  logic [NUM_PROC-1:0][PW-1:0]         gnt_src;
  logic [NUM_PROC-1:0][NUM_PROC-1:0]   cand;
  logic [NUM_PROC-1:0][PW-1:0]         last_q, last_d;
  logic [NUM_PROC-1:0]                 vld_q, vld_d;
  pkt_t [NUM_PROC-1:0]                 pkt_q, pkt_d;

  // Reset gates acceptance so nothing is reported accepted while held in reset.
  assign acceptedOut = packetCoreIn & ~full & {NUM_PROC{rst_l}};

  for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_in
    pkt_fifo #(
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_l (rst_l),
      .push  (acceptedOut[gi]),
      .pop   (pop[gi]),
      .din   (packetSendIn[gi]),
      .head  (head[gi]),
      .empty (empty[gi]),
      .full  (full[gi]),
      .count (occupancy[gi])
    );
  end

  assign ofree = ~vld_q | outReady;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_PROC; i++) begin
      for (int j = 0; j < NUM_PROC; j++) begin
        cand[i][j] = !empty[i] && (head[i].dest == ID_SIZE'(j));
      end
    end
  end

  // Arbiters run independently; a source can win at most one destination
  // because its head names a single dest.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    gnt_vld = '0;
    gnt_src = '0;
    pop     = '0;
    for (int j = 0; j < NUM_PROC; j++) begin
      for (int k = 1; k <= NUM_PROC; k++) begin
        idx = PW'((int'(last_q[j]) + k) % NUM_PROC);
        if (ofree[j] && !gnt_vld[j] && cand[idx][j]) begin
          gnt_vld[j] = 1'b1;
          gnt_src[j] = idx;
        end
      end
    end
    for (int j = 0; j < NUM_PROC; j++) begin
      if (gnt_vld[j]) pop[gnt_src[j]] = 1'b1;
    end
  end

  always_comb begin
    vld_d  = vld_q;
    pkt_d  = pkt_q;
    last_d = last_q;
    for (int j = 0; j < NUM_PROC; j++) begin
      if (gnt_vld[j]) begin
        vld_d[j]  = 1'b1;
        pkt_d[j]  = head[gnt_src[j]];
        last_d[j] = gnt_src[j];
      end else if (ofree[j]) begin
        vld_d[j]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_q  <= '0;
      pkt_q  <= '0;
      last_q <= {NUM_PROC{PW'(NUM_PROC-1)}};
    end else begin
      vld_q  <= vld_d;
      pkt_q  <= pkt_d;
      last_q <= last_d;
    end
  end

  assign received       = vld_q;
  assign packetReceived = pkt_q;

endmodule

// File: tb/tb_buffered_crossbar.sv
// Directed bench for buffered_crossbar with a queue-based reference model
// compared on every falling edge, plus literal scenario expectations.
module tb_buffered_crossbar;
  import NetworkPkg::*;

  localparam int NP = 4;
  localparam int DP = 4;
  localparam int CW = $clog2(DP) + 1;

  logic                 clk = 1'b0;
  logic                 rst_l = 1'b0;
  pkt_t [NP-1:0]        send;
  logic [NP-1:0]        core;
  logic [NP-1:0]        acc;
  logic [NP-1:0]        full;
  logic [NP-1:0][CW-1:0] occ;
  pkt_t [NP-1:0]        prcv;
  logic [NP-1:0]        rcv;
  logic [NP-1:0]        ordy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  buffered_crossbar #(.NUM_PROC(NP), .DEPTH(DP)) dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .packetSendIn   (send),
    .packetCoreIn   (core),
    .acceptedOut    (acc),
    .full           (full),
    .occupancy      (occ),
    .packetReceived (prcv),
    .received       (rcv),
    .outReady       (ordy)
  );

  function automatic pkt_t mk(int s, int d, int a);
    pkt_t p;
    p.src           = ID_SIZE'(s);
    p.dest          = ID_SIZE'(d);
    p.memoryAddress = DATA_WIDTH'(a);
    return p;
  endfunction

  task automatic chk(string nm, int idx, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h at %0t", nm, idx, act, exp, $time);
    end
  endtask

  // Reference model: per-source queues, per-destination held packet,
  // per-destination last granted source.
  pkt_t mq [NP][$];
  bit   mv [NP];
  pkt_t mp [NP];
  int   lg [NP];

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      mq[i].delete();
      mv[i] = 1'b0;
      mp[i] = '0;
      lg[i] = NP - 1;
    end
  endtask

  task automatic model_step();
    int g [NP];
    bit am [NP];
    int s;
    for (int i = 0; i < NP; i++) am[i] = core[i] && (mq[i].size() < DP);
    for (int j = 0; j < NP; j++) begin
      g[j] = -1;
      if (!mv[j] || ordy[j]) begin
        for (int k = 1; k <= NP; k++) begin
          s = (lg[j] + k) % NP;
          if (g[j] < 0 && mq[s].size() > 0 && int'(mq[s][0].dest) == j) g[j] = s;
        end
      end
    end
    for (int j = 0; j < NP; j++) begin
      if (g[j] >= 0) begin
        mp[j] = mq[g[j]].pop_front();
        mv[j] = 1'b1;
        lg[j] = g[j];
      end else if (!mv[j] || ordy[j]) begin
        mv[j] = 1'b0;
      end
    end
    for (int i = 0; i < NP; i++) if (am[i]) mq[i].push_back(send[i]);
  endtask

  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      chk("m_acc",  i, acc[i],  longint'(rst_l && core[i] && (mq[i].size() < DP)));
      chk("m_full", i, full[i], longint'(mq[i].size() == DP));
      chk("m_occ",  i, occ[i],  longint'(mq[i].size()));
      chk("m_rcv",  i, rcv[i],  longint'(mv[i]));
      if (mv[i]) chk("m_pkt", i, prcv[i], mp[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    core  = '0;
    send  = '0;
    ordy  = '0;
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
  endtask

  initial begin
    int n;
    core  = '0;
    send  = '0;
    ordy  = '0;
    repeat (2) @(posedge clk);
    #1;
    core = '1;
    #1;
    chk("rst_acc", 0, acc, 0);
    core  = '0;
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_rcv",  0, rcv,  0);
    chk("rst_occ",  0, occ,  0);
    chk("rst_full", 0, full, 0);
    chk("rst_pkt",  0, prcv, 0);
    tick();

    // Single packet, two-cycle latency
    do_reset();
    ordy    = '1;
    core    = 4'b0100;
    send[2] = mk(2, 1, 'h100);
    tick();
    core = '0;
    chk("lat_occ1", 2, occ[2], 1);
    chk("lat_rcv0", 1, rcv[1], 0);
    tick();
    chk("lat_rcv", 1, rcv[1], 1);
    chk("lat_addr", 1, prcv[1].memoryAddress, 'h100);
    chk("lat_src", 1, prcv[1].src, 2);
    chk("lat_occ0", 2, occ[2], 0);

    // Round-robin across four sources to dest 3
    do_reset();
    core = '1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NP; i++) send[i] = mk(i, 3, 16 * i + r);
      tick();
    end
    core = '0;
    chk("rr_occ0", 0, occ[0], 2);
    chk("rr_occ1", 1, occ[1], 3);
    ordy[3] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_src",  k, rcv[3] ? longint'(prcv[3].src) : 'hF, k % 4);
      chk("rr_addr", k, prcv[3].memoryAddress, 16 * (k % 4) + k / 4);
      tick();
    end
    @(negedge clk);
    chk("rr_done", 3, rcv[3], 0);
    tick();

    // Back-pressure: DEPTH queued plus one held
    do_reset();
    core[0] = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      send[0] = mk(0, 2, 'h200 + n);
      @(negedge clk);
      if (c == 5) begin
        chk("bp_acc6", 0, acc[0], 0);
        chk("bp_full", 0, full[0], 1);
        chk("bp_occ", 0, occ[0], 4);
      end
      if (acc[0]) n++;
      tick();
    end
    core = '0;
    chk("bp_count", 0, n, 5);
    chk("bp_rcv", 2, rcv[2], 1);
    chk("bp_addr", 2, prcv[2].memoryAddress, 'h200);
    tick();
    tick();
    chk("bp_hold_rcv", 2, rcv[2], 1);
    chk("bp_hold_addr", 2, prcv[2].memoryAddress, 'h200);
    chk("bp_hold_occ", 0, occ[0], 4);

    // Head-of-line blocking
    do_reset();
    ordy    = 4'b0100;
    core[0] = 1'b1;
    send[0] = mk(0, 1, 'h301);
    tick();
    send[0] = mk(0, 1, 'h302);
    tick();
    send[0] = mk(0, 2, 'h303);
    tick();
    core = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hol_blk", c, rcv[2], 0);
      tick();
    end
    ordy[1] = 1'b1;
    tick();
    @(negedge clk);
    chk("hol_wait", 2, rcv[2], 0);
    tick();
    @(negedge clk);
    chk("hol_rcv", 2, rcv[2], 1);
    chk("hol_addr", 2, prcv[2].memoryAddress, 'h303);
    tick();

    // All destinations grant in the same cycle
    do_reset();
    ordy = '1;
    core = '1;
    for (int i = 0; i < NP; i++) send[i] = mk(i, (i + 1) % NP, 'h400 + i);
    tick();
    core = '0;
    chk("par_rcv0", 0, rcv, 0);
    tick();
    chk("par_rcv", 0, rcv, 'hF);
    for (int j = 0; j < NP; j++) chk("par_src", j, prcv[j].src, (j + 3) % NP);

    // Reset mid-burst, then first contention goes to input 0
    do_reset();
    core[0] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      send[0] = mk(0, 0, 'h500 + r);
      tick();
    end
    core = '0;
    chk("mr_occ", 0, occ[0], 3);
    chk("mr_rcv", 0, rcv[0], 1);
    #1;
    rst_l = 1'b0;
    core  = '1;
    #1;
    chk("mr_occ_clr", 0, occ, 0);
    chk("mr_rcv_clr", 0, rcv, 0);
    chk("mr_acc_clr", 0, acc, 0);
    @(negedge clk);
    #2;
    rst_l = 1'b1;
    ordy  = '1;
    for (int i = 0; i < NP; i++) send[i] = mk(i, 0, 'h600 + i);
    tick();
    core = '0;
    tick();
    chk("mr_first_rcv", 0, rcv[0], 1);
    chk("mr_first_src", 0, prcv[0].src, 0);
    tick();
    chk("mr_second_src", 0, prcv[0].src, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buffered_crossbar.md
BUFFERED_CROSSBAR -- requirements
Module: buffered_crossbar

Interface
REQ-001 SHALL have parameter NUM_PROC, default 4, meaning the number of ports; power of two, at least 2.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the per-input FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge.
REQ-004 SHALL have port rst_l  input  1  asynchronous active-low reset.
REQ-005 SHALL have port packetSendIn  input  [NUM_PROC-1:0] pkt_t  per-source packet (src, dest, memoryAddress).
REQ-006 SHALL have port packetCoreIn  input  [NUM_PROC-1:0]  per-source push request.
REQ-007 SHALL have port acceptedOut  output  [NUM_PROC-1:0]  push accepted this cycle.
REQ-008 SHALL have port full  output  [NUM_PROC-1:0]  input FIFO i holds DEPTH entries.
REQ-009 SHALL have port occupancy  output  [NUM_PROC-1:0][$clog2(DEPTH):0]  entries in input FIFO i.
REQ-010 SHALL have port packetReceived  output  [NUM_PROC-1:0] pkt_t  per-destination delivered packet.
REQ-011 SHALL have port received  output  [NUM_PROC-1:0]  packetReceived[j] valid.
REQ-012 SHALL have port outReady  input  [NUM_PROC-1:0]  destination j consumes its packet this cycle.

Function
REQ-013 SHALL compute acceptedOut[i] combinationally as packetCoreIn[i] && !full[i]; an accepted packet is written to FIFO i at the posedge.
REQ-014 SHALL derive full[i] only from registered occupancy; a pop in the same cycle SHALL NOT permit a push into a full FIFO.
REQ-015 SHALL ignore packetSendIn[i] when acceptedOut[i] is 0; a rejected packet is not stored, and the source retries.
REQ-016 SHALL give occupancy[i] the value pushes minus pops since reset; a simultaneous push and pop leaves it unchanged.
REQ-017 SHALL wrap FIFO pointers modulo DEPTH.
REQ-018 SHALL preserve packet order per source, and per (source, destination) pair.
REQ-019 SHALL hold one output register (valid plus pkt_t) for each destination j.
REQ-020 SHALL treat output register j as free in a cycle when it is empty, or when received[j] && outReady[j].
REQ-021 SHALL make FIFO i a candidate for destination j when the FIFO is non-empty and its head dest == j.
REQ-022 SHALL, when output j is free, grant one candidate by round-robin starting at lastGrant[j]+1 mod NUM_PROC.
REQ-023 SHALL, on a grant, load the head packet into output register j, pop FIFO i, and set lastGrant[j]=i.
REQ-024 SHALL leave lastGrant[j] unchanged when there is no grant.
REQ-025 SHALL allow every destination to grant in the same cycle; an input can never be granted twice because its head has a single dest.
REQ-026 SHALL impose head-of-line blocking: a blocked head stalls its FIFO; no bypass.
REQ-027 SHALL have a latency of 2 cycles: a packet accepted at edge N, into an empty FIFO with output free, has received[j]=1 after edge N+1.
REQ-028 SHALL sustain a throughput of one packet per destination per cycle while outReady stays high.
REQ-029 SHALL hold packetReceived[j] and received[j] stable while received[j] && !outReady[j]; outReady while received=0 has no effect.
REQ-030 SHALL deliver a packet with src == dest normally.
REQ-031 SHALL pass the packet through unmodified from input to output.

Reset
REQ-032 SHALL, on rst_l low, immediately and asynchronously clear all FIFOs, occupancy=0, full=0, received=0, packetReceived=0, and lastGrant[j]=NUM_PROC-1 (input 0 first).
REQ-033 SHALL discard all queued and held packets on a reset mid-operation; the first grant after release follows REQ-022 from the reset pointers.
REQ-034 SHALL keep acceptedOut at 0 while rst_l is low.

Structure
REQ-035 SHALL take pkt_t, ID_SIZE and DATA_WIDTH from the shared NetworkPkg; add rr_ptr_t there as logic [$clog2(NUM_PROC)-1:0].
REQ-036 SHALL implement each input queue as a sub-module pkt_fifo #(DEPTH) with ports push, pop, head, empty, full, count; instantiate it NUM_PROC times.
REQ-037 SHALL keep the arbiter and output registers in buffered_crossbar; no clock divider inside the block.

Verification
REQ-038 SHALL cover: NUM_PROC=4, reset, input 2 pushes {src2,dest1,addr 0x100} at edge 0 with outReady=1 -> received[1]=1 and packetReceived[1].memoryAddress=0x100 after edge 1, occupancy[2] back to 0.
REQ-039 SHALL cover: inputs 0-3 each hold 3 packets to dest 3, outReady[3]=1 -> grant order 0,1,2,3,0,1,2,3,0,1,2,3, one per cycle.
REQ-040 SHALL cover: DEPTH=4, outReady=0, input 0 pushes 6 packets to dest 2 -> 5 accepted (4 queued plus 1 held in the output), full[0]=1, 6th acceptedOut=0; output held stable.
REQ-041 SHALL cover: input 0 head to dest 1 blocked by outReady[1]=0, next entry to dest 2 -> dest 2 receives nothing until outReady[1] rises.
REQ-042 SHALL cover: the four inputs target four distinct destinations in the same cycle -> all four received the same cycle.
REQ-043 SHALL cover: rst_l dropped mid-burst with 3 queued -> occupancy=0 and received=0 immediately; after release input 0 wins the first contention.
